fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
Read-side controller for the dual-clock almost-full/almost-empty FIFO. It runs entirely in the FIFO read clock domain and programs the FIFO's almost-empty threshold. It drains the FIFO in fixed-length bursts only when a whole burst is guaranteed present, and presents the words to the downstream interpolator core as a valid/ready stream with a burst-last marker. It absorbs the FIFO RAM's 1-cycle registered read latency with a 2-entry output skid buffer.

Parameters:
DATA_WIDTH, 32, word width; must match the FIFO.
ADDR_WIDTH, 4, FIFO address bits; depth MAX_NUM = 2**ADDR_WIDTH.
BURST_LEN, 4, burst length used after reset and for clamped illegal requests; range 1..MAX_NUM.

Ports:
Read_clock___i  in  1  FIFO read clock, posedge active.
rst_async_la_i  in  1  asynchronous reset, low active.
enable_i  in  1  high: start new bursts when data is available.
burst_len_i  in  ADDR_WIDTH+1  requested burst length, sampled at burst start.
fifo_empty_i  in  1  FIFO Empty flag.
fifo_almost_empty_i  in  1  FIFO Almost_Empty flag.
fifo_data_i  in  DATA_WIDTH  FIFO read data; valid 1 cycle after the read strobe.
fifo_read_enable_o  out  1  FIFO read strobe.
fifo_differenceAE_o  out  ADDR_WIDTH  almost-empty threshold driven into the FIFO.
m_data_o  out  DATA_WIDTH  output word.
m_valid_o  out  1  output word valid.
m_last_o  out  1  marks the final word of a burst; qualified by m_valid_o.
m_ready_i  in  1  downstream accepts the word.
busy_o  out  1  high in any state other than IDLE.
burst_count_o  out  16  number of completed bursts, wraps modulo 2**16.

Behaviour:
- Reset values: len_r = BURST_LEN, state = IDLE. All outputs are 0 except fifo_differenceAE_o = BURST_LEN-1. The skid buffer is emptied and the in-flight flag is cleared.
- Length sampling: len_r is loaded from burst_len_i on the IDLE->ARM transition.
  - burst_len_i = 0 is loaded as 1.
  - burst_len_i > MAX_NUM is loaded as MAX_NUM.
- Threshold: fifo_differenceAE_o = len_r-1, driven combinationally from len_r. When the FIFO reports not almost-empty and not empty, it holds at least len_r words. The read-domain count is pessimistic, so this guarantee is safe.
- FSM:
  - IDLE -> ARM when enable_i = 1.
  - ARM -> BURST when fifo_empty_i = 0 and fifo_almost_empty_i = 0. On this transition remaining = len_r.
  - ARM -> IDLE when enable_i = 0.
  - BURST -> DRAIN in the cycle remaining reaches 0.
  - DRAIN -> IDLE once the word tagged last has been accepted (m_valid_o & m_ready_i & m_last_o). On that cycle burst_count_o increments.
- enable_i is ignored once in BURST or DRAIN; the current burst always completes. The next burst needs enable_i again, sampled in IDLE.
- Read issue: fifo_read_enable_o = (state == BURST) & (remaining != 0) & ~fifo_empty_i & credit.
  - credit = (occ + inflight - pop) < 2, where occ is skid buffer occupancy (0..2), inflight is the registered previous strobe, and pop = m_valid_o & m_ready_i.
  - Each strobe decrements remaining.
  - The strobe whose remaining is 1 sets the in-flight last tag.
- An empty indication during BURST stalls reads; no strobe is issued and remaining is held. The FIFO-side gating also makes this safe.
- Latency: strobe at cycle t; fifo_data_i is captured at the end of t+1; m_valid_o is high from cycle t+2. With m_ready_i held high, sustained throughput is 1 word/cycle.
- Skid buffer:
  - 2-entry, in-order, holding data and last tag.
  - Push and pop in the same cycle are allowed.
  - Never overflows; credit guarantees this.
- Stream rule: while m_valid_o = 1 and m_ready_i = 0, m_data_o and m_last_o hold stable.
- Asynchronous reset mid-burst discards buffered and in-flight words. The FIFO read pointer has already advanced, so the data is lost by design.

Test Plan:
- Reset: assert rst_async_la_i = 0 mid-burst -> all outputs 0 immediately; fifo_differenceAE_o = 3 (BURST_LEN = 4); state IDLE.
- Single burst, burst_len_i = 4, FIFO holds 6 words, m_ready_i = 1 -> 4 consecutive read strobes; m_valid_o high 4 consecutive cycles starting 2 cycles after the first strobe; m_last_o on word 4; burst_count_o = 1.
- Insufficient data, burst_len_i = 4, FIFO holds 3 words (almost-empty high) -> no strobes, state stays ARM. A 4th write arrives -> the burst starts.
- Backpressure, burst_len_i = 8, m_ready_i toggling 1,0,0,1,... -> occ + inflight never exceeds 2; all 8 words delivered in order with no duplicates; m_data_o stable while stalled.
- Clamping: burst_len_i = 0 -> single-word bursts with m_last_o on every word and fifo_differenceAE_o = 0. burst_len_i = 31 (ADDR_WIDTH = 4) -> 16-word burst and fifo_differenceAE_o = 15.
- enable_i deasserted during word 2 of 4 -> burst completes with all 4 words; FSM returns to IDLE and starts no new burst; burst_count_o wraps 65535 -> 0 when preloaded by repeated bursts.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drains the dual-clock FIFO in fixed-length bursts into a valid/ready stream with a last marker.
// Latency: strobe at t, word valid at t+2; a 2-entry skid buffer plus read credit absorbs m_ready_i stalls.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                  Read_clock___i,
  input  logic                  rst_async_la_i,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH:0]   burst_len_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_almost_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_read_enable_o,
  output logic [ADDR_WIDTH-1:0] fifo_differenceAE_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic [15:0]           burst_count_o
);

  localparam int MAX_NUM = 2**ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] len_t;

  localparam len_t MAX_LEN   = len_t'(MAX_NUM);
  localparam len_t RESET_LEN = len_t'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_BURST,
    S_DRAIN
  } state_t;

  state_t state_r, state_nxt;

  len_t len_r;
  len_t remaining_r;
  len_t len_clamped;
  logic load_len;
  logic load_rem;

  logic inflight_r;
  logic inflight_last_r;

  logic [1:0]            occ_r;
  logic [DATA_WIDTH-1:0] slot0_dat, slot1_dat;
  logic                  slot0_last, slot1_last;

  logic       rd_en;
  logic       pop;
  logic       push;
  logic       credit;
  logic [2:0] pending;

  // Out-of-range requests are folded into 1..MAX_NUM before they reach len_r.
  always_comb begin
    len_clamped = burst_len_i;
    if (burst_len_i == '0) begin
      len_clamped = len_t'(1);
    end else if (burst_len_i > MAX_LEN) begin
      len_clamped = MAX_LEN;
    end
  end

  assign fifo_differenceAE_o = ADDR_WIDTH'(len_r - len_t'(1));

  assign pop  = m_valid_o & m_ready_i;
  assign push = inflight_r;

  // Words already owed to the skid buffer must leave room for the one this strobe will return.
  assign pending = {1'b0, occ_r} + {2'b00, inflight_r};
  assign credit  = pending < (3'd2 + {2'b00, pop});

  assign rd_en = (state_r == S_BURST) & (remaining_r != '0) & ~fifo_empty_i & credit;
  assign fifo_read_enable_o = rd_en;

  assign busy_o    = (state_r != S_IDLE);
  assign m_valid_o = (occ_r != 2'd0);
  assign m_data_o  = slot0_dat;
  assign m_last_o  = slot0_last & m_valid_o;

  always_ff @(posedge Read_clock___i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    load_len  = 1'b0;
    load_rem  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (enable_i) begin
          state_nxt = S_ARM;
          load_len  = 1'b1;
        end
      end
      S_ARM: begin
        if (!fifo_empty_i && !fifo_almost_empty_i) begin
          state_nxt = S_BURST;
          load_rem  = 1'b1;
        end else if (!enable_i) begin
          state_nxt = S_IDLE;
        end
      end
      S_BURST: begin
        if ((remaining_r == '0) || (rd_en && (remaining_r == len_t'(1)))) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_last_o) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Read_clock___i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      len_r           <= RESET_LEN;
      remaining_r     <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      burst_count_o   <= 16'd0;
    end else begin
      if (load_len) begin
        len_r <= len_clamped;
      end
      if (load_rem) begin
        remaining_r <= len_r;
      end else if (rd_en) begin
        remaining_r <= remaining_r - len_t'(1);
      end
      inflight_r      <= rd_en;
      inflight_last_r <= rd_en & (remaining_r == len_t'(1));
      if (pop && m_last_o) begin
        burst_count_o <= burst_count_o + 16'd1;
      end
    end
  end

  // slot0 is always the head; simultaneous push/pop keeps occupancy unchanged.
  always_ff @(posedge Read_clock___i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      occ_r      <= 2'd0;
      slot0_dat  <= '0;
      slot1_dat  <= '0;
      slot0_last <= 1'b0;
      slot1_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_r == 2'd0) begin
            slot0_dat  <= fifo_data_i;
            slot0_last <= inflight_last_r;
          end else begin
            slot1_dat  <= fifo_data_i;
            slot1_last <= inflight_last_r;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          slot0_dat  <= slot1_dat;
          slot0_last <= slot1_last;
          occ_r      <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            slot0_dat  <= fifo_data_i;
            slot0_last <= inflight_last_r;
          end else begin
            slot0_dat  <= slot1_dat;
            slot0_last <= slot1_last;
            slot1_dat  <= fifo_data_i;
            slot1_last <= inflight_last_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader: behavioural FIFO plus an in-order word/burst scoreboard.
module tb_fifo_burst_reader;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int MAXN = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [AW:0]   blen;
  logic          fifo_empty;
  logic          fifo_ae;
  logic [DW-1:0] fifo_dat;
  logic          rd;
  logic [AW-1:0] dae;
  logic [DW-1:0] m_dat;
  logic          m_vld;
  logic          m_last;
  logic          m_rdy;
  logic          busy;
  logic [15:0]   bcount;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(4)) dut (
    .Read_clock___i      (clk),
    .rst_async_la_i      (rst_n),
    .enable_i            (enable),
    .burst_len_i         (blen),
    .fifo_empty_i        (fifo_empty),
    .fifo_almost_empty_i (fifo_ae),
    .fifo_data_i         (fifo_dat),
    .fifo_read_enable_o  (rd),
    .fifo_differenceAE_o (dae),
    .m_data_o            (m_dat),
    .m_valid_o           (m_vld),
    .m_last_o            (m_last),
    .m_ready_i           (m_rdy),
    .busy_o              (busy),
    .burst_count_o       (bcount)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  int          scyc[$];
  int          vcyc[$];
  int          cyc, nstrobe, npop, lc, brd, wcnt, wr_left, wr_pct, rdy_mode;
  logic [15:0] bcnt;
  logic        prev_stall, prev_last;
  logic [31:0] prev_dat;
  bit          ae_chk, log_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int clamp_len(input int r);
    if (r == 0) return 1;
    if (r > MAXN) return MAXN;
    return r;
  endfunction

  task automatic upd_flags();
    fifo_empty = (fq.size() == 0);
    fifo_ae    = (fq.size() <= int'(dae));
  endtask

  task automatic push_word();
    logic [31:0] w;
    w = $urandom;
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic begin_phase(input int req);
    blen   = 5'(req);
    lc     = clamp_len(req);
    brd    = 0;
    wcnt   = 0;
    ae_chk = 1'b1;
  endtask

  // One clock: sample and score at negedge, then advance the FIFO model just after posedge.
  task automatic tick();
    logic        rd_s, pop_s, exp_last;
    logic [31:0] exp_w;
    @(negedge clk);
    cyc++;
    rd_s  = rd;
    pop_s = m_vld & m_rdy;
    check("burst_count", 32'(bcount), 32'(bcnt));
    check("credit", 32'((nstrobe + int'(rd_s) - npop - int'(pop_s)) <= 2), 32'd1);
    if (prev_stall) begin
      check("hold_vld", 32'(m_vld), 32'd1);
      check("hold_dat", m_dat, prev_dat);
      check("hold_last", 32'(m_last), 32'(prev_last));
    end
    if (busy && ae_chk) check("ae_thresh", 32'(dae), 32'(lc - 1));
    if (rd_s) begin
      check("rd_nonempty", 32'(fq.size() != 0), 32'd1);
      if (brd == 0) check("burst_avail", 32'(fq.size() >= lc), 32'd1);
      brd = (brd + 1 == lc) ? 0 : brd + 1;
      nstrobe++;
      if (log_en) scyc.push_back(cyc);
    end
    if (log_en && m_vld) vcyc.push_back(cyc);
    if (pop_s) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_w    = exp_q.pop_front();
        exp_last = ((wcnt + 1) % lc == 0);
        check("data", m_dat, exp_w);
        check("last", 32'(m_last), 32'(exp_last));
        wcnt++;
        if (exp_last) bcnt++;
      end
      npop++;
    end
    prev_stall = m_vld & ~m_rdy;
    prev_dat   = m_dat;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    if (rd_s && fq.size() != 0) fifo_dat = fq.pop_front();
    if (wr_left > 0 && $urandom_range(99) < wr_pct) begin
      push_word();
      wr_left--;
    end
    upd_flags();
    case (rdy_mode)
      0:       m_rdy = 1'b1;
      1:       m_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_rdy = 1'($urandom_range(1));
    endcase
  endtask

  task automatic run_words(input int n, input int maxc);
    int target;
    target = npop + n;
    for (int i = 0; i < maxc && npop < target; i++) tick();
    check("words_delivered", 32'(npop >= target), 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done   = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy && nstrobe == npop) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  initial begin
    int c0, n0;
    bit ok;
    rst_n = 1'b0; enable = 1'b0; blen = 5'd4; m_rdy = 1'b1; fifo_dat = '0;
    rdy_mode = 0; wr_left = 0; wr_pct = 0; cyc = 0; nstrobe = 0; npop = 0;
    lc = 4; brd = 0; wcnt = 0; bcnt = 16'd0; prev_stall = 1'b0; prev_last = 1'b0;
    prev_dat = '0; ae_chk = 1'b0; log_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    upd_flags();
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_dae", 32'(dae), 32'd3);
    check("rst_vld", 32'(m_vld), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_dat", m_dat, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(bcount), 32'd0);
    rst_n = 1'b1;

    // Single burst of 4 from 6 stored words, ready held high.
    begin_phase(4);
    repeat (6) push_word();
    upd_flags();
    scyc.delete(); vcyc.delete(); log_en = 1'b1;
    enable = 1'b1;
    run_words(4, 50);
    repeat (3) tick();
    log_en = 1'b0;
    check("single_strobes", 32'(scyc.size()), 32'd4);
    check("single_valids", 32'(vcyc.size()), 32'd4);
    if (scyc.size() == 4 && vcyc.size() == 4) begin
      check("strobe_span", 32'(scyc[3] - scyc[0]), 32'd3);
      check("valid_latency", 32'(vcyc[0] - scyc[0]), 32'd2);
      check("valid_span", 32'(vcyc[3] - vcyc[0]), 32'd3);
    end
    check("single_count", 32'(bcount), 32'd1);

    // Only 3 words stored: must wait armed until a 4th arrives.
    push_word();
    upd_flags();
    scyc.delete(); log_en = 1'b1;
    repeat (20) tick();
    check("short_no_strobe", 32'(scyc.size()), 32'd0);
    check("short_armed", 32'(busy), 32'd1);
    push_word();
    upd_flags();
    run_words(4, 50);
    log_en = 1'b0;
    check("short_then_burst", 32'(scyc.size()), 32'd4);
    wait_idle();

    // Backpressure with ready pattern 1,0,0,1.
    begin_phase(8);
    rdy_mode = 1; wr_left = 24; wr_pct = 70; enable = 1'b1;
    run_words(24, 800);
    wait_idle();
    rdy_mode = 0;

    // Length clamping at both ends.
    begin_phase(0);
    wr_left = 5; wr_pct = 100; enable = 1'b1;
    run_words(5, 200);
    wait_idle();
    begin_phase(31);
    rdy_mode = 2; wr_left = 16; wr_pct = 50; enable = 1'b1;
    run_words(16, 400);
    wait_idle();
    check("dae_clamp_hi", 32'(dae), 32'd15);
    rdy_mode = 0;

    // enable dropped during the burst: it still completes, nothing new starts.
    begin_phase(4);
    c0 = int'(bcnt);
    repeat (8) push_word();
    upd_flags();
    scyc.delete(); log_en = 1'b1; enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (scyc.size() >= 2) begin
        enable = 1'b0;
        break;
      end
    end
    for (int i = 0; i < 60 && wcnt < 4; i++) tick();
    repeat (20) tick();
    log_en = 1'b0;
    check("drop_strobes", 32'(scyc.size()), 32'd4);
    check("drop_words", 32'(wcnt), 32'd4);
    check("drop_idle", 32'(busy), 32'd0);
    check("drop_count", 32'(bcount), 32'(c0 + 1));

    // Randomized phases.
    for (int p = 0; p < 6; p++) begin
      begin_phase($urandom_range(0, 20));
      rdy_mode = 2;
      wr_left  = $urandom_range(10, 40);
      wr_pct   = $urandom_range(30, 100);
      enable   = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if (wr_left == 0 && fq.size() < lc && nstrobe == npop && brd == 0 && (wcnt % lc) == 0) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      check("phase_settled", 32'(ok), 32'd1);
      wait_idle();
    end
    rdy_mode = 0;

    // Asynchronous reset in the middle of a burst.
    begin_phase(4);
    repeat (8) push_word();
    upd_flags();
    enable = 1'b1;
    n0 = nstrobe;
    for (int i = 0; i < 40 && nstrobe - n0 < 2; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd", 32'(rd), 32'd0);
    check("mid_rst_vld", 32'(m_vld), 32'd0);
    check("mid_rst_last", 32'(m_last), 32'd0);
    check("mid_rst_dat", m_dat, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(bcount), 32'd0);
    check("mid_rst_dae", 32'(dae), 32'd3);
    #2;
    rst_n = 1'b1;
    fq.delete(); exp_q.delete();
    nstrobe = 0; npop = 0; bcnt = 16'd0; prev_stall = 1'b0; enable = 1'b0;
    upd_flags();
    begin_phase(4);
    repeat (4) push_word();
    upd_flags();
    enable = 1'b1;
    run_words(4, 60);
    wait_idle();
    check("recover_count", 32'(bcount), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
